// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encodings and sizing helpers for the memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IC   = 2'd1,
    ARB_DCRD = 2'd2,
    ARB_DCWR = 2'd3
  } arb_state_e;

  function automatic int beat_width(input int burst_len);
    return $clog2(burst_len);
  endfunction

  // Byte-offset bits inside one cache line; these address bits are dropped at grant.
  function automatic int align_bits(input int burst_len, input int data_width);
    return $clog2(burst_len * data_width / 8);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_beat_counter.sv
// rtl/mem_port_arbiter_beat_counter.sv - beat counter, last-beat flag and beat address generation
module arb_beat_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic                  adv,
  output logic                  last,
  output logic [ADDR_WIDTH-1:0] beat_addr
);

  localparam int BW = beat_width(BURST_LEN);
  localparam int AB = align_bits(BURST_LEN, DATA_WIDTH);

  logic [BW-1:0]         beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;

  assign last      = (beat_q == BW'(BURST_LEN - 1));
  assign beat_addr = base_q + (ADDR_WIDTH'(beat_q) << 2);

  always_comb begin
    beat_d = beat_q;
    base_d = base_q;
    if (load) base_d = load_addr & ({ADDR_WIDTH{1'b1}} << AB);
    // The only way back to beat 0 is completing the last beat.
    if (adv) beat_d = last ? '0 : beat_q + BW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      base_q <= '0;
    end else begin
      beat_q <= beat_d;
      base_q <= base_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between I-cache refill and D-cache refill/writeback
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4,
  parameter int STARVE_MAX = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_rvalid,
  output logic                  ic_done,
  input  logic                  dc_req,
  input  logic                  dc_we,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic [DATA_WIDTH-1:0] dc_wdata,
  output logic                  dc_wready,
  output logic                  dc_rvalid,
  output logic                  dc_done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_e            state_q;
  logic [SW-1:0]         starve_q;
  logic                  mem_req_q, mem_we_q;
  logic                  ack, last, starved, d_grant, i_grant;
  logic [ADDR_WIDTH-1:0] beat_addr;

  assign ack     = mem_req_q & mem_ack;
  assign starved = ic_req && (starve_q == SW'(STARVE_MAX));
  assign d_grant = (state_q == ARB_IDLE) && dc_req && !starved;
  assign i_grant = (state_q == ARB_IDLE) && ic_req && !d_grant;

  arb_beat_counter #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .BURST_LEN (BURST_LEN)
  ) u_beat (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (d_grant | i_grant),
    .load_addr(d_grant ? dc_addr : ic_addr),
    .adv      (ack),
    .last     (last),
    .beat_addr(beat_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      starve_q  <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (d_grant) begin
            state_q   <= dc_we ? ARB_DCWR : ARB_DCRD;
            mem_req_q <= 1'b1;
            mem_we_q  <= dc_we;
            // d_grant with ic_req pending implies starve_q < STARVE_MAX, so no overflow.
            starve_q  <= ic_req ? starve_q + SW'(1) : '0;
          end else if (i_grant) begin
            state_q   <= ARB_IC;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b0;
            starve_q  <= '0;
          end else begin
            starve_q  <= '0;
          end
        end
        default: begin
          if (ack && last) begin
            state_q   <= ARB_IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_req_q ? beat_addr : '0;
  assign mem_wdata = (state_q == ARB_DCWR) ? dc_wdata : '0;
  assign ic_rvalid = ack && (state_q == ARB_IC);
  assign dc_rvalid = ack && (state_q == ARB_DCRD);
  assign dc_wready = ack && (state_q == ARB_DCWR);
  assign ic_done   = ic_rvalid && last;
  assign dc_done   = ack && last && (state_q inside {ARB_DCRD, ARB_DCWR});
  assign rdata     = (ic_rvalid || dc_rvalid) ? mem_rdata : '0;

  a_ic_req_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ARB_IC) |-> ic_req);
  a_dc_req_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q inside {ARB_DCRD, ARB_DCWR}) |-> dc_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BL   = 4;
  localparam int SMAX = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ic_req, ic_rvalid, ic_done;
  logic [AW-1:0] ic_addr;
  logic          dc_req, dc_we, dc_wready, dc_rvalid, dc_done;
  logic [AW-1:0] dc_addr;
  logic [DW-1:0] dc_wdata, rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  int starve_m = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rvalid(ic_rvalid), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wready(dc_wready), .dc_rvalid(dc_rvalid), .dc_done(dc_done),
    .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_checks(input string tag);
    check({tag, ".mem_req"}, mem_req, 0);
    check({tag, ".mem_we"}, mem_we, 0);
    check({tag, ".mem_addr"}, mem_addr, 0);
    check({tag, ".mem_wdata"}, mem_wdata, 0);
    check({tag, ".ic_rvalid"}, ic_rvalid, 0);
    check({tag, ".dc_rvalid"}, dc_rvalid, 0);
    check({tag, ".dc_wready"}, dc_wready, 0);
    check({tag, ".ic_done"}, ic_done, 0);
    check({tag, ".dc_done"}, dc_done, 0);
    check({tag, ".rdata"}, rdata, 0);
  endtask

  // Called half a cycle before the arbiter's IDLE decision edge with requests already driven.
  // mode 0: ack every cycle, 1: ack from pattern bits, 2: random ack (forced after 3 stalls).
  task automatic serve(input int mode, input logic [7:0] pat);
    bit          own_d, wr, ack;
    logic [31:0] base;
    int          k, cyc, stall;
    if (dc_req && !(ic_req && starve_m == SMAX)) begin
      own_d    = 1'b1;
      wr       = dc_we;
      base     = dc_addr & 32'hFFFF_FFF0;
      starve_m = ic_req ? ((starve_m < SMAX) ? starve_m + 1 : starve_m) : 0;
    end else begin
      own_d    = 1'b0;
      wr       = 1'b0;
      base     = ic_addr & 32'hFFFF_FFF0;
      starve_m = 0;
    end
    @(negedge clk);
    k = 0; cyc = 0; stall = 0;
    while (k < BL && cyc < 40) begin
      case (mode)
        0:       ack = 1'b1;
        1:       ack = pat[cyc % 8];
        default: ack = (stall >= 3) || ($urandom_range(0, 1) == 1);
      endcase
      mem_ack   = ack;
      mem_rdata = $urandom;
      dc_wdata  = $urandom;
      #1;
      check("mem_req", mem_req, 1);
      check("mem_we", mem_we, wr);
      check("mem_addr", mem_addr, base + 32'(4 * k));
      check("ic_rvalid", ic_rvalid, !own_d && ack);
      check("dc_rvalid", dc_rvalid, own_d && !wr && ack);
      check("dc_wready", dc_wready, own_d && wr && ack);
      check("ic_done", ic_done, !own_d && ack && (k == BL - 1));
      check("dc_done", dc_done, own_d && ack && (k == BL - 1));
      check("rdata", rdata, (ack && !wr) ? mem_rdata : 32'h0);
      check("mem_wdata", mem_wdata, wr ? dc_wdata : 32'h0);
      if (ack) begin k++; stall = 0; end else stall++;
      cyc++;
      // Owner's address/we wiggle mid-burst; the latched values must win.
      if (mode == 2 && $urandom_range(0, 1) == 1) begin
        if (own_d) begin dc_addr = $urandom; dc_we = 1'($urandom_range(0, 1)); end
        else ic_addr = $urandom;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    if (own_d) dc_req = 1'b0; else ic_req = 1'b0;
    #1;
    idle_checks("post_burst");
  endtask

  initial begin
    rst_n = 1'b0; ic_req = 1'b0; ic_addr = '0; dc_req = 1'b0; dc_we = 1'b0;
    dc_addr = '0; dc_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clk); @(negedge clk);
    idle_checks("reset");
    rst_n = 1'b1;
    @(negedge clk);

    ic_req = 1'b1; ic_addr = 32'h1000;
    serve(0, 8'h00);

    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    idle_checks("idle_ack");
    @(negedge clk);
    mem_ack = 1'b0;
    starve_m = 0;
    ic_req = 1'b1; ic_addr = 32'h1004;
    serve(0, 8'h00);

    ic_req = 1'b1; ic_addr = 32'h3000;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h4000;
    serve(2, 8'h00);
    serve(2, 8'h00);

    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h2008;
    serve(1, 8'b0010_1101);

    ic_req = 1'b1; ic_addr = 32'h5000;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h6000;
    serve(0, 8'h00);
    dc_req = 1'b1; dc_addr = 32'h6010;
    serve(0, 8'h00);
    dc_req = 1'b1; dc_addr = 32'h6020;
    serve(0, 8'h00);
    serve(0, 8'h00);

    ic_req = 1'b1; ic_addr = 32'h1000;
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      mem_ack = 1'b1;
      #1;
      check("rst_pre_addr", mem_addr, 32'h1000 + 32'(4 * b));
      @(negedge clk);
    end
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    check("rst_beat2_addr", mem_addr, 32'h1008);
    rst_n = 1'b0;
    #1;
    idle_checks("rst_mid");
    @(negedge clk);
    mem_ack = 1'b0;
    rst_n = 1'b1;
    starve_m = 0;
    serve(0, 8'h00);

    repeat (40) begin
      if (!ic_req && $urandom_range(0, 1) == 1) begin
        ic_req = 1'b1; ic_addr = $urandom;
      end
      if (!dc_req && $urandom_range(0, 1) == 1) begin
        dc_req = 1'b1; dc_we = 1'($urandom_range(0, 1)); dc_addr = $urandom;
      end
      if (ic_req || dc_req) begin
        serve(2, 8'h00);
      end else begin
        mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        #1;
        idle_checks("rand_idle");
        starve_m = 0;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
